// File: rtl/edge_event_arbiter.sv
// ============================================================================
// Module   : edge_event_arbiter
// Brief    : Rising-edge event collector with round-robin valid/ready delivery.
//            Optional sticky per-channel overflow flags under EDGE_ARB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_event_arbiter #(
  parameter int N_CH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       trig,
  input  logic [N_CH-1:0]       enable,
  output logic                  evt_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] evt_ch,
  input  logic                  evt_ready,
`ifdef EDGE_ARB_OVF_EN
  input  logic [N_CH-1:0]       ovf_clr,
  output logic [N_CH-1:0]       ovf,
`endif
  output logic [N_CH-1:0]       pending
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [N_CH-1:0]    r_prev_trig;
  logic [N_CH-1:0]    r_pending;
  logic [N_CH-1:0]    w_edge;
  logic [N_CH-1:0]    w_clr;
  logic [N_CH-1:0]    w_rot;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_rr_nxt;
  logic [IDX_W-1:0]   r_evt_ch;
  logic [IDX_W-1:0]   w_ch_nxt;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W:0]     w_off;
  logic [IDX_W:0]     w_sum;
  logic               r_evt_valid;
  logic               w_valid_nxt;
  logic               w_hs;
  logic               w_found;

  assign w_edge = trig & ~r_prev_trig & enable;
  assign w_hs   = r_evt_valid & evt_ready;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_clr[i] = w_hs && (r_evt_ch == IDX_W'(i));
    end
  end

  // Rotate pending so bit 0 is the round-robin pointer, then take the lowest set bit.
  assign w_rot = N_CH'({r_pending, r_pending} >> r_rr_ptr);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_off   = (IDX_W+1)'(k);
      end
    end
    w_sum = {1'b0, r_rr_ptr} + w_off;
    if (w_sum >= (IDX_W+1)'(N_CH)) begin
      w_sum = w_sum - (IDX_W+1)'(N_CH);
    end
    w_sel = IDX_W'(w_sum);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_evt_valid;
    w_ch_nxt    = r_evt_ch;
    w_rr_nxt    = r_rr_ptr;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_OFFER;
          w_valid_nxt = 1'b1;
          w_ch_nxt    = w_sel;
        end
      end
      S_OFFER: begin
        if (w_hs) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_rr_nxt    = (r_evt_ch == IDX_W'(N_CH - 1)) ? '0 : r_evt_ch + IDX_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // prev_trig resets high so a level already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_ch    <= '0;
      r_rr_ptr    <= '0;
      r_pending   <= '0;
      r_prev_trig <= '1;
    end else begin
      r_evt_valid <= w_valid_nxt;
      r_evt_ch    <= w_ch_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_pending   <= (r_pending & ~w_clr) | w_edge;
      r_prev_trig <= trig;
    end
  end

`ifdef EDGE_ARB_OVF_EN
  logic [N_CH-1:0] r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= (r_ovf & ~ovf_clr) | (w_edge & r_pending & ~w_clr);
    end
  end

  assign ovf = r_ovf;
`endif

  assign evt_valid = r_evt_valid;
  assign evt_ch    = r_evt_ch;
  assign pending   = r_pending;

endmodule

`default_nettype wire
